seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector; next generation of the fixed 3-bit "101" detector.
- Pattern (up to MAX_LEN bits) and its length are loaded at runtime.
- Selectable overlapping or non-overlapping matching.
- Input qualified by a valid strobe; registered match pulse; optional saturating match counter.
- Sits on serial receive paths (framing or sync-word detection) ahead of deserialisers.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, $clog2(MAX_LEN+1), width of the length field
RST_PATTERN, 8'b0000_0101, pattern after reset (LSB-aligned)
RST_LEN, 3, pattern length after reset
CNT_W, 8, match counter width (only with SEQ_DET_CNT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
cfg_load  in  1  load cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the oldest bit, bit [0] the newest
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
in_valid  in  1  in_bit is valid this cycle
in_bit  in  1  serial data bit
found  out  1  one-cycle pulse, registered
match_count  out  CNT_W  saturating number of matches (SEQ_DET_CNT_EN only)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - found=0, match_count=0, history=0, fill=0.
  - pattern=RST_PATTERN, len=RST_LEN, overlap=1. The reset configuration reproduces the legacy overlapping "101" detector.
- State:
  - history shift register, MAX_LEN bits.
  - fill counter, 0..MAX_LEN, saturating; counts valid bits since the last clear.
  - Config registers: pattern, len, overlap.
- Accepted bit (in_valid=1 and cfg_load=0):
  - history <= {history[MAX_LEN-2:0], in_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the updated history:
  - len != 0,
  - fill_next >= len,
  - history_next[len-1:0] == pattern[len-1:0].
- found:
  - Registered; asserts the cycle after the completing bit is accepted (latency 1).
  - Held low in any cycle with no accepted bit.
- Overlap modes on a match:
  - overlap=1: fill is not cleared, so trailing bits may start the next match. With 101, input 10101 gives two matches.
  - overlap=0: fill <= 0 in the same cycle, so no bit is shared between matches. With 101, input 10101 gives one match.
- cfg_load:
  - Loads the config registers and clears history and fill.
  - Takes priority over in_valid; the in_bit offered that cycle is dropped.
  - found=0 the next cycle.
  - match_count is not cleared.
- Length boundaries:
  - cfg_len=0: detection disabled, found never asserts.
  - cfg_len>MAX_LEN: clamped to MAX_LEN at load.
  - Pattern bits above len-1 are ignored.
- in_valid=0: all state holds.
- Reset mid-stream: history, fill and count are discarded and the config returns to the RST_* values.

Optional Feature:
SEQ_DET_CNT_EN
- Defined: match_count port present. Increments by 1 on each found pulse (same edge found is registered). Saturates at 2^CNT_W-1. Cleared only by reset.
- Not defined: match_count port and counter logic absent. All other behaviour is identical.

Decomposition:
- Package seq_det_pkg: default constants (RST_PATTERN, RST_LEN, MAX_LEN default) and the function clamp_len(len, max).
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, q): used for match_count. Also reusable for fill.

Test Plan:
1. Reset config, stream 1,0,1,0,1 with in_valid=1 -> found pulses the cycle after bit 3 and after bit 5; match_count=2.
2. Load pattern 8'b1101_0010, len=8, overlap=0; stream 1101001011010010 -> found after bit 8 and bit 16 only; a 7-bit prefix alone gives no pulse.
3. Load pattern 4'b1111, len=4, overlap=0 vs overlap=1; stream of 8 ones -> 2 pulses (non-overlap) vs 5 pulses (overlap).
4. in_valid gaps: 101 delivered with idle cycles between bits -> exactly one pulse, one cycle after the third valid bit. Assert cfg_load on the cycle the third bit is offered -> no pulse, bit dropped.
5. cfg_len=0 with any stream -> found stays 0. cfg_len=15 with MAX_LEN=8 -> behaves as len=8.
6. CNT_W=2 with SEQ_DET_CNT_EN: 5 matches -> match_count saturates at 3. Synchronous reset mid-pattern (after 10 of 101) then 1 -> no pulse.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: reset defaults and length clamping shared by the sequence detector.
package seq_det_pkg;
  localparam int MAX_LEN_DEF = 8;
  localparam logic [31:0] RST_PATTERN_DEF = 32'h0000_0005;
  localparam int RST_LEN_DEF = 3;
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max);
    return (len > max) ? max : len;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that saturates at MAX; sync reset doubles as clear.
module sat_counter #(
  parameter int W = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (inc && q != MAX) q <= q + 1'b1;
  end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector; SEQ_DET_CNT_EN adds a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] RST_PATTERN = RST_PATTERN_DEF[MAX_LEN-1:0],
  parameter int RST_LEN = RST_LEN_DEF
`ifdef SEQ_DET_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               found
`ifdef SEQ_DET_CNT_EN
  , output logic [CNT_W-1:0] match_count
`endif
);
  logic [MAX_LEN-1:0] pattern_r, hist_next, mask;
  logic [MAX_LEN-2:0] history;
  logic [LEN_W-1:0]   len_r, fill, fill_next;
  logic               overlap_r, accept, match;
  assign accept = in_valid & ~cfg_load;
  // the oldest history bit is shifted out before it can ever be compared, so it is not stored
  assign hist_next = {history, in_bit};
  assign fill_next = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = LEN_W'(i) < len_r;
  end
  assign match = accept && len_r != '0 && fill_next >= len_r && ((hist_next ^ pattern_r) & mask) == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_r <= RST_PATTERN;
      len_r     <= LEN_W'(RST_LEN);
      overlap_r <= 1'b1;
      history   <= '0;
      found     <= 1'b0;
    end else begin
      found <= match;
      if (cfg_load) begin
        pattern_r <= cfg_pattern;
        len_r     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
        overlap_r <= cfg_overlap;
        history   <= '0;
      end else if (accept) history <= hist_next[MAX_LEN-2:0];
    end
  end
  sat_counter #(.W(LEN_W), .MAX(LEN_W'(MAX_LEN))) u_fill (
    .clk   (clk),
    .reset (reset | cfg_load | (match & ~overlap_r)),
    .inc   (accept),
    .q     (fill)
  );
`ifdef SEQ_DET_CNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .q     (match_count)
  );
`endif
endmodule
